// File: rtl/pipe_mips32_fwd.sv
// Single-clock 5-stage MIPS32-subset pipeline with full forwarding, load-use interlock and branch flush.
// Branches resolve in EX; HLT freezes fetch in ID and stops the whole core once it reaches WB.
module pipe_mips32_fwd #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 10,
    parameter int DMEM_AW = 10,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               dmem_we,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               halted,
    output logic [CNT_W-1:0]   retire_cnt,
    input  logic [4:0]         dbg_raddr,
    output logic [DATA_W-1:0]  dbg_rdata
);
    localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02, OP_OR = 6'h03;
    localparam logic [5:0] OP_SLT = 6'h04, OP_MUL = 6'h05, OP_LW = 6'h08, OP_SW = 6'h09;
    localparam logic [5:0] OP_ADDI = 6'h0A, OP_SUBI = 6'h0B, OP_SLTI = 6'h0C;
    localparam logic [5:0] OP_BNEQZ = 6'h0D, OP_BEQZ = 6'h0E;

    typedef enum logic [2:0] {K_RR, K_RI, K_LW, K_SW, K_BNEQZ, K_BEQZ, K_HLT} kind_t;

    function automatic kind_t decode(input logic [5:0] op);
        kind_t k;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: k = K_RR;
            OP_ADDI, OP_SUBI, OP_SLTI:                     k = K_RI;
            OP_LW:    k = K_LW;
            OP_SW:    k = K_SW;
            OP_BNEQZ: k = K_BNEQZ;
            OP_BEQZ:  k = K_BEQZ;
            default:  k = K_HLT;
        endcase
        return k;
    endfunction

    logic [IMEM_AW-1:0] pc;
    logic               fetch_stop;
    logic               ifid_valid;
    logic [31:0]        ifid_ir;
    logic [IMEM_AW-1:0] ifid_npc;
    logic               idex_valid, idex_wen;
    kind_t              idex_kind;
    logic [5:0]         idex_op;
    logic [4:0]         idex_rs, idex_rt, idex_dest;
    logic [DATA_W-1:0]  idex_a, idex_b, idex_imm;
    logic [IMEM_AW-1:0] idex_npc;
    logic               exmem_valid, exmem_load, exmem_store, exmem_hlt, exmem_wen;
    logic [4:0]         exmem_dest;
    logic [DATA_W-1:0]  exmem_alu, exmem_sd;
    logic               memwb_valid, memwb_hlt, memwb_wen;
    logic [4:0]         memwb_dest;
    logic [DATA_W-1:0]  memwb_val;
    logic [DATA_W-1:0]  rf [0:31];

    // ---------------- ID ----------------
    kind_t             id_kind;
    logic [4:0]        id_rs, id_rt;
    logic              id_use_rs, id_use_rt, wb_we, load_use, stall, freeze, flush;
    logic [DATA_W-1:0] id_a, id_b;

    assign id_kind   = decode(ifid_ir[31:26]);
    assign id_rs     = ifid_ir[25:21];
    assign id_rt     = ifid_ir[20:16];
    assign id_use_rs = id_kind != K_HLT;
    assign id_use_rt = id_kind == K_RR || id_kind == K_SW;
    assign wb_we     = memwb_valid && memwb_wen && memwb_dest != 5'd0 && !halted;

    // Write-first: the value retiring this cycle is visible to the instruction in ID.
    assign id_a = (wb_we && memwb_dest == id_rs) ? memwb_val : rf[id_rs];
    assign id_b = (wb_we && memwb_dest == id_rt) ? memwb_val : rf[id_rt];

    assign load_use = idex_valid && idex_kind == K_LW && idex_rt != 5'd0 && ifid_valid &&
                      ((id_use_rs && id_rs == idex_rt) || (id_use_rt && id_rt == idex_rt));
    assign stall  = load_use && !flush;
    assign freeze = fetch_stop || (ifid_valid && id_kind == K_HLT && !flush);

    // ---------------- EX ----------------
    logic [DATA_W-1:0]  ex_a, ex_b, ex_res;
    logic               ex_taken;
    logic [IMEM_AW-1:0] ex_target;
    logic               fwd_mem_ok, fwd_wb_ok;

    assign fwd_mem_ok = exmem_valid && exmem_wen && exmem_dest != 5'd0;
    assign fwd_wb_ok  = memwb_valid && memwb_wen && memwb_dest != 5'd0;

    always_comb begin
        ex_a = idex_a;
        ex_b = idex_b;
        if (fwd_wb_ok && memwb_dest == idex_rs)  ex_a = memwb_val;
        if (fwd_mem_ok && exmem_dest == idex_rs) ex_a = exmem_alu;
        if (fwd_wb_ok && memwb_dest == idex_rt)  ex_b = memwb_val;
        if (fwd_mem_ok && exmem_dest == idex_rt) ex_b = exmem_alu;
    end

    always_comb begin
        ex_res   = '0;
        ex_taken = 1'b0;
        case (idex_kind)
            K_RR: begin
                case (idex_op)
                    OP_ADD:  ex_res = ex_a + ex_b;
                    OP_SUB:  ex_res = ex_a - ex_b;
                    OP_AND:  ex_res = ex_a & ex_b;
                    OP_OR:   ex_res = ex_a | ex_b;
                    OP_SLT:  ex_res[0] = $signed(ex_a) < $signed(ex_b);
                    OP_MUL:  ex_res = ex_a * ex_b;
                    default: ex_res = '0;
                endcase
            end
            K_RI: begin
                case (idex_op)
                    OP_ADDI: ex_res = ex_a + idex_imm;
                    OP_SUBI: ex_res = ex_a - idex_imm;
                    OP_SLTI: ex_res[0] = $signed(ex_a) < $signed(idex_imm);
                    default: ex_res = '0;
                endcase
            end
            K_LW, K_SW: ex_res = ex_a + idex_imm;
            K_BNEQZ:    ex_taken = ex_a != '0;
            K_BEQZ:     ex_taken = ex_a == '0;
            default:    ex_res = '0;
        endcase
    end

    assign ex_target = idex_npc + idex_imm[IMEM_AW-1:0];
    assign flush     = idex_valid && ex_taken && !halted;

    // ---------------- outputs ----------------
    assign imem_addr  = pc;
    assign dmem_addr  = exmem_alu[DMEM_AW-1:0];
    assign dmem_wdata = exmem_sd;
    assign dmem_we    = exmem_valid && exmem_store && !halted;
    assign dbg_rdata  = rf[dbg_raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[memwb_dest] <= memwb_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            fetch_stop  <= 1'b0;
            halted      <= 1'b0;
            retire_cnt  <= '0;
            ifid_valid  <= 1'b0;
            ifid_ir     <= '0;
            ifid_npc    <= '0;
            idex_valid  <= 1'b0;
            idex_wen    <= 1'b0;
            idex_kind   <= K_RR;
            idex_op     <= '0;
            idex_rs     <= '0;
            idex_rt     <= '0;
            idex_dest   <= '0;
            idex_a      <= '0;
            idex_b      <= '0;
            idex_imm    <= '0;
            idex_npc    <= '0;
            exmem_valid <= 1'b0;
            exmem_load  <= 1'b0;
            exmem_store <= 1'b0;
            exmem_hlt   <= 1'b0;
            exmem_wen   <= 1'b0;
            exmem_dest  <= '0;
            exmem_alu   <= '0;
            exmem_sd    <= '0;
            memwb_valid <= 1'b0;
            memwb_hlt   <= 1'b0;
            memwb_wen   <= 1'b0;
            memwb_dest  <= '0;
            memwb_val   <= '0;
        end else if (!halted) begin
            if (memwb_valid && memwb_hlt) halted <= 1'b1;
            if (memwb_valid && !memwb_hlt) retire_cnt <= retire_cnt + 1'b1;
            if (ifid_valid && id_kind == K_HLT && !flush) fetch_stop <= 1'b1;

            if (flush)        pc <= ex_target;
            else if (!stall && !freeze) pc <= pc + 1'b1;

            if (flush || (freeze && !stall)) begin
                ifid_valid <= 1'b0;
            end else if (!stall) begin
                ifid_valid <= 1'b1;
                ifid_ir    <= imem_rdata;
                ifid_npc   <= pc + 1'b1;
            end

            idex_valid <= ifid_valid && !flush && !stall;
            idex_kind  <= id_kind;
            idex_op    <= ifid_ir[31:26];
            idex_rs    <= id_rs;
            idex_rt    <= id_rt;
            idex_dest  <= (id_kind == K_RR) ? ifid_ir[15:11] : id_rt;
            idex_wen   <= id_kind == K_RR || id_kind == K_RI || id_kind == K_LW;
            idex_a     <= id_a;
            idex_b     <= id_b;
            idex_imm   <= DATA_W'($signed(ifid_ir[15:0]));
            idex_npc   <= ifid_npc;

            exmem_valid <= idex_valid;
            exmem_load  <= idex_kind == K_LW;
            exmem_store <= idex_kind == K_SW;
            exmem_hlt   <= idex_kind == K_HLT;
            exmem_wen   <= idex_wen;
            exmem_dest  <= idex_dest;
            exmem_alu   <= ex_res;
            exmem_sd    <= ex_b;

            memwb_valid <= exmem_valid;
            memwb_hlt   <= exmem_hlt;
            memwb_wen   <= exmem_wen;
            memwb_dest  <= exmem_dest;
            memwb_val   <= exmem_load ? dmem_rdata : exmem_alu;
        end
    end
endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// Directed-program bench for pipe_mips32_fwd: small programs with hand-computed register,
// memory, cycle-count and retire-count results, plus mid-run reset and unknown-opcode halt.
module tb_pipe_mips32_fwd;
    localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, AND_ = 6'h02, OR_ = 6'h03, SLT = 6'h04;
    localparam logic [5:0] MUL = 6'h05, LW = 6'h08, SW = 6'h09, ADDI = 6'h0A, SUBI = 6'h0B;
    localparam logic [5:0] SLTI = 6'h0C, BNEQZ = 6'h0D, BEQZ = 6'h0E, HLT = 6'h3F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  imem_addr, dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, dbg_rdata, retire_cnt;
    logic        dmem_we, halted;
    logic [4:0]  dbg_raddr = 5'd0;
    logic [31:0] imem [0:1023];
    logic [31:0] dmem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    pipe_mips32_fwd dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .halted(halted), .retire_cnt(retire_cnt),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    always @(posedge clk) if (dmem_we) dmem[dmem_addr] <= dmem_wdata;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs, rt, rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        dbg_raddr = r;
        #1;
        v = dbg_rdata;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = {HLT, 26'd0};
    endtask

    // Releases reset on a negedge and counts posedges until halted is seen.
    task automatic run_prog(output int cycles);
        cycles = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
            if (halted) break;
        end
    endtask

    int          cyc;
    logic [31:0] v;

    initial begin
        // ---- test 1: forwarding without stalls ----
        rst_n = 1'b0;
        clear_imem();
        #1;
        check_val("rst_imem_addr", imem_addr, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_retire", retire_cnt, 0);
        check_val("rst_dmem_we", dmem_we, 0);
        imem[0] = enc_i(ADDI, 0, 1, 16'd10);
        imem[1] = enc_i(ADDI, 0, 2, 16'd20);
        imem[2] = enc_r(ADD, 1, 2, 3);
        run_prog(cyc);
        check_val("t1_halted", halted, 1);
        check_val("t1_cycles", cyc, 8);
        read_reg(3, v); check_val("t1_r3", v, 30);
        check_val("t1_retire", retire_cnt, 3);

        // ---- test 2: store, load, load-use stall ----
        rst_n = 1'b0;
        clear_imem();
        imem[0] = enc_i(ADDI, 0, 1, 16'd7);
        imem[1] = enc_i(SW, 0, 1, 16'd5);
        imem[2] = enc_i(LW, 0, 4, 16'd5);
        imem[3] = enc_r(ADD, 4, 4, 5);
        run_prog(cyc);
        check_val("t2_halted", halted, 1);
        check_val("t2_cycles_one_stall", cyc, 10);
        check_val("t2_dmem5", dmem[5], 7);
        read_reg(4, v); check_val("t2_r4", v, 7);
        read_reg(5, v); check_val("t2_r5", v, 14);
        check_val("t2_retire", retire_cnt, 4);

        // ---- test 3: loop with taken branches and flushed shadow ----
        rst_n = 1'b0;
        clear_imem();
        imem[0] = enc_i(ADDI, 0, 1, 16'd3);
        imem[1] = enc_i(SUBI, 1, 1, 16'd1);
        imem[2] = enc_i(BNEQZ, 1, 0, 16'hFFFE);
        imem[3] = enc_i(BEQZ, 0, 0, 16'd1);
        imem[4] = enc_i(ADDI, 0, 6, 16'd5);
        imem[5] = enc_i(ADDI, 0, 9, 16'd1);
        run_prog(cyc);
        check_val("t3_halted", halted, 1);
        check_val("t3_cycles", cyc, 20);
        read_reg(1, v); check_val("t3_r1", v, 0);
        read_reg(9, v); check_val("t3_r9", v, 1);
        read_reg(6, v); check_val("t3_r6_shadow", v, 0);
        check_val("t3_retire", retire_cnt, 9);

        // ---- test 4: signed compares, r0, ALU ops ----
        rst_n = 1'b0;
        clear_imem();
        imem[0] = enc_i(ADDI, 0, 1, 16'hFFFF);
        imem[1] = enc_i(ADDI, 0, 2, 16'd1);
        imem[2] = enc_r(SLT, 1, 2, 3);
        imem[3] = enc_i(SLTI, 2, 4, 16'hFFFF);
        imem[4] = enc_r(ADD, 1, 1, 0);
        imem[5] = enc_r(ADD, 0, 2, 10);
        imem[6] = enc_r(SUB, 2, 1, 5);
        imem[7] = enc_r(MUL, 5, 5, 6);
        imem[8] = enc_r(AND_, 1, 2, 7);
        imem[9] = enc_r(OR_, 6, 2, 8);
        run_prog(cyc);
        check_val("t4_halted", halted, 1);
        read_reg(1, v);  check_val("t4_r1", v, 32'hFFFF_FFFF);
        read_reg(3, v);  check_val("t4_r3_slt", v, 1);
        read_reg(4, v);  check_val("t4_r4_slti", v, 0);
        read_reg(0, v);  check_val("t4_r0", v, 0);
        read_reg(10, v); check_val("t4_r10_no_r0_fwd", v, 1);
        read_reg(5, v);  check_val("t4_r5_sub", v, 2);
        read_reg(6, v);  check_val("t4_r6_mul", v, 4);
        read_reg(7, v);  check_val("t4_r7_and", v, 1);
        read_reg(8, v);  check_val("t4_r8_or", v, 5);
        check_val("t4_retire", retire_cnt, 10);

        // ---- test 5: asynchronous reset mid-loop ----
        rst_n = 1'b0;
        clear_imem();
        imem[0] = enc_i(ADDI, 0, 1, 16'd50);
        imem[1] = enc_i(SUBI, 1, 1, 16'd1);
        imem[2] = enc_i(SW, 0, 1, 16'd0);
        imem[3] = enc_i(BNEQZ, 1, 0, 16'hFFFD);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        read_reg(1, v);
        check_val("t5_pre_r1_nonzero", v != 0, 1);
        check_val("t5_pre_retire_nonzero", retire_cnt != 0, 1);
        rst_n = 1'b0;
        #1;
        check_val("t5_imem_addr", imem_addr, 0);
        check_val("t5_dmem_we", dmem_we, 0);
        check_val("t5_dmem_addr", dmem_addr, 0);
        check_val("t5_halted", halted, 0);
        check_val("t5_retire", retire_cnt, 0);
        check_val("t5_r1", dbg_rdata, 0);

        // ---- test 6: unknown opcode halts ----
        clear_imem();
        imem[0] = {6'h2A, 26'd0};
        imem[1] = enc_i(ADDI, 0, 7, 16'd1);
        run_prog(cyc);
        check_val("t6_halted", halted, 1);
        check_val("t6_cycles", cyc, 5);
        check_val("t6_imem_addr", imem_addr, 1);
        repeat (20) @(posedge clk);
        #1;
        read_reg(7, v); check_val("t6_r7", v, 0);
        check_val("t6_imem_addr_after20", imem_addr, 1);
        check_val("t6_retire_after20", retire_cnt, 0);
        check_val("t6_halted_after20", halted, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
